config_readback_rx: RTL and testbench

Bridge-side serial receiver for configuration readback. It samples the returned serial stream (clock, select, data) on the fast PLL clock and deserializes it into the 16-bit dynamic and 88-bit static configuration words. It compares each completed word against an expected value and reports match, framing errors and a saturating error count. It sits beside the configuration writer FSMs and consumes the chip's MISO line together with the serial clock and select that the bridge drives.

---
 rtl/config_readback_rx.sv | 212 +++++++++++++++++++++
 tb/tb_config_readback_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/config_readback_rx.sv
// config_readback_rx: samples the serial readback stream (SCLK/SEL/SDI) on the
// fast clock and deserializes it into the dynamic and static configuration words.
// Each completed word is compared against its expected value. Frame aborts and
// mismatching frames are tallied in a saturating error counter.
module config_readback_rx #(
    parameter int                    SIZESRDYN   = 16,
    parameter int                    SIZESRSTAT  = 88,
    parameter logic [SIZESRDYN-1:0]  EXP_DYN     = 16'h4321,
    parameter logic [SIZESRSTAT-1:0] EXP_STAT    = 88'hFEDCBA9876543210012345,
    parameter int                    TIMEOUT_CYC = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK,
    input  logic                  SEL,
    input  logic                  SDI,
    output logic [SIZESRDYN-1:0]  DYN_WORD,
    output logic [SIZESRSTAT-1:0] STAT_WORD,
    output logic                  DYN_VALID,
    output logic                  STAT_VALID,
    output logic                  DYN_MATCH,
    output logic                  STAT_MATCH,
    output logic                  FRAME_ERR,
    output logic [7:0]            ERR_COUNT
);

    // The shared shift register is sized for the longer of the two frames.
    localparam int SH_W  = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] DYN_LEN   = CNT_W'(SIZESRDYN);
    localparam logic [CNT_W-1:0] STAT_LEN  = CNT_W'(SIZESRSTAT);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

    // ---------------- input synchronizers ----------------
    logic [2:0] sync_in;
    logic [2:0] sync_s2;
    logic       sclk_s3_reg;

    assign sync_in = {SCLK, SEL, SDI};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : sync_g
            logic s1_reg;
            logic s2_reg;
            // Two-flop synchronizer for one serial input.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= sync_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s2[gi] = s2_reg;
        end
    endgenerate

    logic sclk_s2, sel_s2, sdi_s2, sclk_rise;
    assign sclk_s2   = sync_s2[2];
    assign sel_s2    = sync_s2[1];
    assign sdi_s2    = sync_s2[0];
    assign sclk_rise = sclk_s2 & ~sclk_s3_reg;

    // Extra SCLK stage used only for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (!RST_N) sclk_s3_reg <= 1'b0;
        else        sclk_s3_reg <= sclk_s2;
    end

    // ---------------- frame FSM and datapath ----------------
    state_t                  state_reg, state_next;
    logic                    frame_sel_reg, frame_sel_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [TMO_W-1:0]        tmo_reg, tmo_next;
    logic [SH_W-1:0]         shift_reg, shift_next;
    logic [SIZESRDYN-1:0]    dyn_word_reg, dyn_word_next;
    logic [SIZESRSTAT-1:0]   stat_word_reg, stat_word_next;
    logic                    dyn_valid_reg, dyn_valid_next;
    logic                    stat_valid_reg, stat_valid_next;
    logic                    dyn_match_reg, dyn_match_next;
    logic                    stat_match_reg, stat_match_next;
    logic                    frame_err_reg, frame_err_next;
    logic [7:0]              err_count_reg, err_count_next;

    logic                    err_bump;
    logic [CNT_W-1:0]        cnt_inc;
    logic [TMO_W-1:0]        tmo_inc;
    logic [CNT_W-1:0]        frame_len;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic plus next values for every datapath/output register.
    always_comb begin
        state_next      = state_reg;
        frame_sel_next  = frame_sel_reg;
        bit_cnt_next    = bit_cnt_reg;
        tmo_next        = tmo_reg;
        shift_next      = shift_reg;
        dyn_word_next   = dyn_word_reg;
        stat_word_next  = stat_word_reg;
        dyn_valid_next  = 1'b0;
        stat_valid_next = 1'b0;
        dyn_match_next  = dyn_match_reg;
        stat_match_next = stat_match_reg;
        frame_err_next  = 1'b0;
        err_bump        = 1'b0;
        cnt_inc         = bit_cnt_reg + CNT_W'(1);
        tmo_inc         = tmo_reg + TMO_W'(1);
        frame_len       = frame_sel_reg ? DYN_LEN : STAT_LEN;

        case (state_reg)
            IDLE: begin
                if (sclk_rise) begin
                    state_next     = SHIFT;
                    frame_sel_next = sel_s2;
                    shift_next     = {{(SH_W-1){1'b0}}, sdi_s2};
                    bit_cnt_next   = CNT_W'(1);
                    tmo_next       = '0;
                end
            end
            SHIFT: begin
                // A select change mid-frame wins over any edge in the same cycle.
                if (sel_s2 != frame_sel_reg) begin
                    state_next = ERR;
                end else if (sclk_rise) begin
                    shift_next   = {shift_reg[SH_W-2:0], sdi_s2};
                    bit_cnt_next = cnt_inc;
                    tmo_next     = '0;
                    if (cnt_inc == frame_len) state_next = DONE;
                end else begin
                    tmo_next = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) state_next = ERR;
                end
            end
            DONE: begin
                if (frame_sel_reg) begin
                    dyn_word_next  = shift_reg[SIZESRDYN-1:0];
                    dyn_valid_next = 1'b1;
                    dyn_match_next = (shift_reg[SIZESRDYN-1:0] == EXP_DYN);
                    err_bump       = (shift_reg[SIZESRDYN-1:0] != EXP_DYN);
                end else begin
                    stat_word_next  = shift_reg[SIZESRSTAT-1:0];
                    stat_valid_next = 1'b1;
                    stat_match_next = (shift_reg[SIZESRSTAT-1:0] == EXP_STAT);
                    err_bump        = (shift_reg[SIZESRSTAT-1:0] != EXP_STAT);
                end
                state_next = IDLE;
            end
            ERR: begin
                frame_err_next = 1'b1;
                err_bump       = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (err_bump && (err_count_reg != 8'hFF))
            err_count_next = err_count_reg + 8'd1;
        else
            err_count_next = err_count_reg;
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            frame_sel_reg  <= 1'b0;
            bit_cnt_reg    <= '0;
            tmo_reg        <= '0;
            shift_reg      <= '0;
            dyn_word_reg   <= '0;
            stat_word_reg  <= '0;
            dyn_valid_reg  <= 1'b0;
            stat_valid_reg <= 1'b0;
            dyn_match_reg  <= 1'b0;
            stat_match_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_count_reg  <= 8'd0;
        end else begin
            frame_sel_reg  <= frame_sel_next;
            bit_cnt_reg    <= bit_cnt_next;
            tmo_reg        <= tmo_next;
            shift_reg      <= shift_next;
            dyn_word_reg   <= dyn_word_next;
            stat_word_reg  <= stat_word_next;
            dyn_valid_reg  <= dyn_valid_next;
            stat_valid_reg <= stat_valid_next;
            dyn_match_reg  <= dyn_match_next;
            stat_match_reg <= stat_match_next;
            frame_err_reg  <= frame_err_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign DYN_WORD   = dyn_word_reg;
    assign STAT_WORD  = stat_word_reg;
    assign DYN_VALID  = dyn_valid_reg;
    assign STAT_VALID = stat_valid_reg;
    assign DYN_MATCH  = dyn_match_reg;
    assign STAT_MATCH = stat_match_reg;
    assign FRAME_ERR  = frame_err_reg;
    assign ERR_COUNT  = err_count_reg;

endmodule

// File: tb/tb_config_readback_rx.sv
// Testbench for config_readback_rx: table of full frames plus hand-written
// sequences for timeout, select change, mid-frame reset and counter saturation.
module tb_config_readback_rx;

    localparam logic [87:0] EXP_STAT_TB = 88'hFEDCBA9876543210012345;
    localparam int          TMO_TB      = 64;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         SCLK = 1'b0;
    logic         SEL = 1'b0;
    logic         SDI = 1'b0;
    logic [15:0]  DYN_WORD;
    logic [87:0]  STAT_WORD;
    logic         DYN_VALID, STAT_VALID, DYN_MATCH, STAT_MATCH, FRAME_ERR;
    logic [7:0]   ERR_COUNT;

    config_readback_rx dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SCLK       (SCLK),
        .SEL        (SEL),
        .SDI        (SDI),
        .DYN_WORD   (DYN_WORD),
        .STAT_WORD  (STAT_WORD),
        .DYN_VALID  (DYN_VALID),
        .STAT_VALID (STAT_VALID),
        .DYN_MATCH  (DYN_MATCH),
        .STAT_MATCH (STAT_MATCH),
        .FRAME_ERR  (FRAME_ERR),
        .ERR_COUNT  (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled on the falling edge.
    int dyn_v_cnt = 0;
    int stat_v_cnt = 0;
    int ferr_cnt = 0;
    always @(negedge CLK) begin
        if (DYN_VALID)  dyn_v_cnt  <= dyn_v_cnt + 1;
        if (STAT_VALID) stat_v_cnt <= stat_v_cnt + 1;
        if (FRAME_ERR)  ferr_cnt   <= ferr_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // One serial bit: SCLK low 2 cycles with data set, high 4, low 2.
    task automatic send_bit(input logic b);
        SDI = b;
        repeat (2) @(negedge CLK);
        SCLK = 1'b1;
        repeat (4) @(negedge CLK);
        SCLK = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_bits(input logic sel, input int len, input logic [87:0] data, input int nbits);
        SEL = sel;
        for (int i = 0; i < nbits; i++) send_bit(data[len-1-i]);
    endtask

    typedef struct {
        logic        sel;
        int          len;
        logic [87:0] data;
        logic [87:0] exp_word;
        logic        exp_match;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b_dv, b_sv, b_fe, first_n;

        vecs[0] = '{1'b1, 16, 88'h4321, 88'h4321, 1'b1, 8'd0};
        vecs[1] = '{1'b0, 88, 88'h123456789ABCDEF1234567, 88'h123456789ABCDEF1234567, 1'b0, 8'd1};
        vecs[2] = '{1'b0, 88, EXP_STAT_TB, EXP_STAT_TB, 1'b1, 8'd1};
        vecs[3] = '{1'b1, 16, 88'hFFFF, 88'hFFFF, 1'b0, 8'd2};
        vecs[4] = '{1'b1, 16, 88'h4321, 88'h4321, 1'b1, 8'd2};

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_dyn_word", 128'(DYN_WORD), 128'h0);
        check("rst_stat_word", 128'(STAT_WORD), 128'h0);
        check("rst_flags", {DYN_VALID, STAT_VALID, DYN_MATCH, STAT_MATCH, FRAME_ERR}, 5'b0);
        check("rst_err_count", 128'(ERR_COUNT), 128'h0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Table of full frames.
        for (int v = 0; v < 5; v++) begin
            b_dv = dyn_v_cnt; b_sv = stat_v_cnt; b_fe = ferr_cnt;
            send_bits(vecs[v].sel, vecs[v].len, vecs[v].data, vecs[v].len);
            repeat (2) @(negedge CLK);
            $display("frame %0d sel=%0b data=%0h", v, vecs[v].sel, vecs[v].data);
            check($sformatf("v%0d_dyn_valid", v), 128'(dyn_v_cnt - b_dv), vecs[v].sel ? 128'd1 : 128'd0);
            check($sformatf("v%0d_stat_valid", v), 128'(stat_v_cnt - b_sv), vecs[v].sel ? 128'd0 : 128'd1);
            check($sformatf("v%0d_frame_err", v), 128'(ferr_cnt - b_fe), 128'd0);
            if (vecs[v].sel) begin
                check($sformatf("v%0d_dyn_word", v), 128'(DYN_WORD), 128'(vecs[v].exp_word[15:0]));
                check($sformatf("v%0d_dyn_match", v), 128'(DYN_MATCH), 128'(vecs[v].exp_match));
            end else begin
                check($sformatf("v%0d_stat_word", v), 128'(STAT_WORD), 128'(vecs[v].exp_word));
                check($sformatf("v%0d_stat_match", v), 128'(STAT_MATCH), 128'(vecs[v].exp_match));
            end
            check($sformatf("v%0d_err_count", v), 128'(ERR_COUNT), 128'(vecs[v].exp_err));
        end

        // Timeout: 6 normal bits, then a 7th after which SCLK stops.
        b_dv = dyn_v_cnt; b_fe = ferr_cnt;
        send_bits(1'b1, 16, 88'hABCD, 6);
        SDI = 1'b1;
        repeat (2) @(negedge CLK);
        SCLK = 1'b1;
        first_n = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge CLK);
            if (n == 4) SCLK = 1'b0;
            if (FRAME_ERR && first_n == 0) first_n = n;
        end
        // Drive -> s1 (1) -> s2 (2) -> shift (3), then TIMEOUT_CYC idle cycles to ERR, one more to FRAME_ERR.
        check("tmo_latency", 128'(first_n), 128'(TMO_TB + 4));
        check("tmo_frame_err_cnt", 128'(ferr_cnt - b_fe), 128'd1);
        check("tmo_no_valid", 128'(dyn_v_cnt - b_dv), 128'd0);
        check("tmo_dyn_word", 128'(DYN_WORD), 128'h4321);
        check("tmo_dyn_match", 128'(DYN_MATCH), 128'd1);
        check("tmo_err_count", 128'(ERR_COUNT), 128'd3);

        // Full ABCD frame after the aborted one.
        b_dv = dyn_v_cnt;
        send_bits(1'b1, 16, 88'hABCD, 16);
        repeat (2) @(negedge CLK);
        check("abcd_valid", 128'(dyn_v_cnt - b_dv), 128'd1);
        check("abcd_dyn_word", 128'(DYN_WORD), 128'hABCD);
        check("abcd_dyn_match", 128'(DYN_MATCH), 128'd0);
        check("abcd_err_count", 128'(ERR_COUNT), 128'd4);

        // Select toggled after bit 5 of a static frame.
        b_sv = stat_v_cnt; b_fe = ferr_cnt;
        send_bits(1'b0, 88, 88'h123456789ABCDEF1234567, 5);
        SEL = 1'b1;
        repeat (8) @(negedge CLK);
        check("sel_frame_err", 128'(ferr_cnt - b_fe), 128'd1);
        check("sel_no_valid", 128'(stat_v_cnt - b_sv), 128'd0);
        check("sel_stat_word", 128'(STAT_WORD), 128'(EXP_STAT_TB));
        check("sel_stat_match", 128'(STAT_MATCH), 128'd1);
        check("sel_err_count", 128'(ERR_COUNT), 128'd5);

        // Reset at bit 40 of a static frame.
        b_fe = ferr_cnt;
        send_bits(1'b0, 88, EXP_STAT_TB, 40);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("mrst_dyn_word", 128'(DYN_WORD), 128'h0);
        check("mrst_stat_word", 128'(STAT_WORD), 128'h0);
        check("mrst_flags", {DYN_VALID, STAT_VALID, DYN_MATCH, STAT_MATCH, FRAME_ERR}, 5'b0);
        check("mrst_err_count", 128'(ERR_COUNT), 128'h0);
        check("mrst_no_frame_err", 128'(ferr_cnt - b_fe), 128'd0);
        b_sv = stat_v_cnt;
        send_bits(1'b0, 88, EXP_STAT_TB, 88);
        repeat (2) @(negedge CLK);
        check("post_rst_valid", 128'(stat_v_cnt - b_sv), 128'd1);
        check("post_rst_stat_word", 128'(STAT_WORD), 128'(EXP_STAT_TB));
        check("post_rst_stat_match", 128'(STAT_MATCH), 128'd1);
        check("post_rst_err_count", 128'(ERR_COUNT), 128'd0);

        // 300 aborted frames: one bit with SEL=1, then SEL drops.
        for (int k = 1; k <= 300; k++) begin
            SEL = 1'b1;
            send_bit(1'b0);
            SEL = 1'b0;
            repeat (6) @(negedge CLK);
            if (k == 254) check("sat_254", 128'(ERR_COUNT), 128'hFE);
            if (k == 255) check("sat_255", 128'(ERR_COUNT), 128'hFF);
        end
        check("sat_300", 128'(ERR_COUNT), 128'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
